// File: rtl/enc_cap_pkg.sv
// enc_cap_pkg
// Shared constants for the encoder capture FIFO: default depth and counter
// width, entry field positions, timestamp width and entry width.
// Build option: define ENC_CAP_TIMESTAMP_EN to append a 32-bit capture
// timestamp above the channel bit of every entry.
package enc_cap_pkg;

    localparam int P_DEPTH_DEF = 16;
    localparam int P_CNT_W_DEF = 64;
    localparam int TS_W        = 32;

`ifdef ENC_CAP_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Entry layout, LSB first: count, overflow flag, channel, [timestamp]
    function automatic int ovf_pos(int cnt_w);
        return cnt_w;
    endfunction

    function automatic int ch_pos(int cnt_w);
        return cnt_w + 1;
    endfunction

    function automatic int ts_lsb(int cnt_w);
        return cnt_w + 2;
    endfunction

    function automatic int entry_w(int cnt_w);
        return TS_EN ? cnt_w + 2 + TS_W : cnt_w + 2;
    endfunction

    localparam int ENTRY_W_DEF = entry_w(P_CNT_W_DEF);

    typedef enum logic {
        CH_0 = 1'b0,
        CH_1 = 1'b1
    } chan_e;

endpackage

// File: rtl/enc_capture_fifo_if.sv
// enc_capture_fifo_if
// Bundles the capture FIFO's encoder inputs, drop-counter clear and the
// FWFT consumer side.
//   ready_0/1, cnt_0/1, overflow_0/1 : encoder channel levels and counts
//   clr_drop                         : synchronous clear of drop counter
//   valid, tready, data              : FWFT output handshake and entry
//   level                            : FIFO occupancy
//   drop_cnt                         : saturating lost-capture count
// Modports: slave = capture FIFO, master = encoder/consumer side.
interface enc_capture_fifo_if
    import enc_cap_pkg::*;
#(
    parameter int P_DEPTH = P_DEPTH_DEF,
    parameter int P_CNT_W = P_CNT_W_DEF,
    parameter int W       = entry_w(P_CNT_W),
    parameter int LVL_W   = $clog2(P_DEPTH) + 1
) ();

    logic               ready_0;
    logic               ready_1;
    logic [P_CNT_W-1:0] cnt_0;
    logic [P_CNT_W-1:0] cnt_1;
    logic               overflow_0;
    logic               overflow_1;
    logic               clr_drop;
    logic               valid;
    logic               tready;
    logic [W-1:0]       data;
    logic [LVL_W-1:0]   level;
    logic [15:0]        drop_cnt;

    modport slave (
        input  ready_0, ready_1, cnt_0, cnt_1, overflow_0, overflow_1,
        input  clr_drop, tready,
        output valid, data, level, drop_cnt
    );

    modport master (
        output ready_0, ready_1, cnt_0, cnt_1, overflow_0, overflow_1,
        output clr_drop, tready,
        input  valid, data, level, drop_cnt
    );

endinterface

// File: rtl/enc_cap_fifo.sv
// enc_cap_fifo
// Synchronous first-word-fall-through FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   wr_en    : write request (ignored while full, even with a same-cycle read)
//   wr_data  : entry to store
//   rd_en    : pop request (ignored while empty)
//   rd_data  : oldest entry, meaningful while empty=0
//   level    : occupancy 0..P_DEPTH
//   full     : level == P_DEPTH
//   empty    : level == 0
module enc_cap_fifo
    import enc_cap_pkg::*;
#(
    parameter int P_DEPTH = P_DEPTH_DEF,
    parameter int W       = ENTRY_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(P_DEPTH):0]   level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW    = $clog2(P_DEPTH);
    localparam int LVL_W = AW + 1;

    logic [W-1:0]    mem [P_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_wr;
    logic            do_rd;

    always_comb begin
        full    = (level == LVL_W'(P_DEPTH));
        empty   = (level == '0);
        do_wr   = wr_en & ~full;
        do_rd   = rd_en & ~empty;
        rd_data = mem[rd_ptr];
    end

    // Pointers wrap naturally since P_DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/enc_capture_fifo.sv
// enc_capture_fifo
// Captures the encoder count of a channel on each rising edge of its ready
// level, holds it in a per-channel pending register and writes it into a
// FWFT FIFO, channel 0 first when both are pending. Captures arriving while
// a channel's pending register is still occupied are dropped and counted.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : enc_capture_fifo_if.slave (encoder inputs, FIFO output,
//              level, drop counter, drop clear)
// Build option: ENC_CAP_TIMESTAMP_EN adds a free-running 32-bit timestamp
// sampled with each capture and stored above the channel bit.
module enc_capture_fifo
    import enc_cap_pkg::*;
#(
    parameter int P_DEPTH = P_DEPTH_DEF,
    parameter int P_CNT_W = P_CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    enc_capture_fifo_if.slave   bus
);

    localparam int W     = entry_w(P_CNT_W);
    localparam int OVF_B = ovf_pos(P_CNT_W);
    localparam int CH_B  = ch_pos(P_CNT_W);

    logic               prev_0, prev_1;
    logic               armed;
    logic               pend_v_0, pend_v_1;
    logic [P_CNT_W-1:0] pend_cnt_0, pend_cnt_1;
    logic               pend_ovf_0, pend_ovf_1;
    logic [15:0]        drop_cnt;

    logic               ev_0, ev_1;
    logic               wr_en, wr_0, wr_1;
    chan_e              wr_sel;
    logic               free_0, free_1;
    logic               take_0, take_1;
    logic               drop_0, drop_1;
    logic [16:0]        drop_add;
    logic [15:0]        drop_next;
    logic [W-1:0]       wr_data;
    logic [W-1:0]       rd_data;
    logic               full, empty;

`ifdef ENC_CAP_TIMESTAMP_EN
    localparam int TS_B = ts_lsb(P_CNT_W);
    logic [TS_W-1:0]    ts;
    logic [TS_W-1:0]    pend_ts_0, pend_ts_1;
`endif

    always_comb begin
        // armed stays low for the first edge after reset so a ready level
        // already high at release is only registered, never captured
        ev_0   = armed & bus.ready_0 & ~prev_0;
        ev_1   = armed & bus.ready_1 & ~prev_1;
        wr_en  = (pend_v_0 | pend_v_1) & ~full;
        wr_sel = pend_v_0 ? CH_0 : CH_1;
        wr_0   = wr_en & (wr_sel == CH_0);
        wr_1   = wr_en & (wr_sel == CH_1);
        // A pending register being written this edge can accept a new capture
        free_0 = ~pend_v_0 | wr_0;
        free_1 = ~pend_v_1 | wr_1;
        take_0 = ev_0 & free_0;
        take_1 = ev_1 & free_1;
        drop_0 = ev_0 & ~free_0;
        drop_1 = ev_1 & ~free_1;
        drop_add  = {1'b0, drop_cnt} + {16'b0, drop_0} + {16'b0, drop_1};
        drop_next = drop_add[16] ? 16'hFFFF : drop_add[15:0];
    end

    always_comb begin
        wr_data = '0;
        if (wr_sel == CH_0) begin
            wr_data[P_CNT_W-1:0] = pend_cnt_0;
            wr_data[OVF_B]       = pend_ovf_0;
        end else begin
            wr_data[P_CNT_W-1:0] = pend_cnt_1;
            wr_data[OVF_B]       = pend_ovf_1;
        end
        wr_data[CH_B] = (wr_sel == CH_1);
`ifdef ENC_CAP_TIMESTAMP_EN
        wr_data[TS_B +: TS_W] = (wr_sel == CH_0) ? pend_ts_0 : pend_ts_1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_0     <= 1'b0;
            prev_1     <= 1'b0;
            armed      <= 1'b0;
            pend_v_0   <= 1'b0;
            pend_v_1   <= 1'b0;
            pend_cnt_0 <= '0;
            pend_cnt_1 <= '0;
            pend_ovf_0 <= 1'b0;
            pend_ovf_1 <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            prev_0 <= bus.ready_0;
            prev_1 <= bus.ready_1;
            armed  <= 1'b1;

            if (take_0) begin
                pend_v_0   <= 1'b1;
                pend_cnt_0 <= bus.cnt_0;
                pend_ovf_0 <= bus.overflow_0;
            end else if (wr_0) begin
                pend_v_0 <= 1'b0;
            end

            if (take_1) begin
                pend_v_1   <= 1'b1;
                pend_cnt_1 <= bus.cnt_1;
                pend_ovf_1 <= bus.overflow_1;
            end else if (wr_1) begin
                pend_v_1 <= 1'b0;
            end

            if (bus.clr_drop) drop_cnt <= '0;
            else              drop_cnt <= drop_next;
        end
    end

`ifdef ENC_CAP_TIMESTAMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts        <= '0;
            pend_ts_0 <= '0;
            pend_ts_1 <= '0;
        end else begin
            ts <= ts + TS_W'(1);
            if (take_0) pend_ts_0 <= ts;
            if (take_1) pend_ts_1 <= ts;
        end
    end
`endif

    enc_cap_fifo #(
        .P_DEPTH (P_DEPTH),
        .W       (W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (bus.tready),
        .rd_data (rd_data),
        .level   (bus.level),
        .full    (full),
        .empty   (empty)
    );

    assign bus.valid    = ~empty;
    assign bus.data     = rd_data;
    assign bus.drop_cnt = drop_cnt;

endmodule
